// File: rtl/alu_rs.sv
// Reservation station in front of the combinational ALU array. Entry i feeds ALU lane i;
// waiting operands are woken by snooping the per-lane result bus.
module alu_rs #(
  parameter int unsigned size = 8,
  parameter int unsigned TAGW = 4,
  localparam int unsigned CntW = $clog2(size + 1),
  localparam int unsigned IdxW = (size > 1) ? $clog2(size) : 1,
  localparam int unsigned EntW = 3 + 32 + 32 + TAGW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           dis_valid,
  input  logic [2:0]                     dis_op,
  input  logic [TAGW-1:0]                dis_tag,
  input  logic [31:0]                    dis_r1,
  input  logic [31:0]                    dis_r2,
  input  logic [TAGW-1:0]                dis_q1,
  input  logic [TAGW-1:0]                dis_q2,
  input  logic                           dis_v1,
  input  logic                           dis_v2,
  output logic                           full,
  output logic [CntW-1:0]                count,
  output logic [size-1:0][EntW-1:0]      alu_data,
  output logic [size-1:0]                alu_ready,
  input  logic [size-1:0][31:0]          cdb_data,
  input  logic [size-1:0][TAGW-1:0]      cdb_tag,
  input  logic [size-1:0]                cdb_rdy
);

  logic [size-1:0]            busy_q, busy_d;
  logic [size-1:0][2:0]       op_q, op_d;
  logic [size-1:0][TAGW-1:0]  tag_q, tag_d;
  logic [size-1:0][31:0]      r1_q, r1_d, r2_q, r2_d;
  logic [size-1:0][TAGW-1:0]  q1_q, q1_d, q2_q, q2_d;
  logic [size-1:0]            v1_q, v1_d, v2_q, v2_d;

  logic            alloc_hit;
  logic [IdxW-1:0] alloc_idx;

  function automatic logic cdb_hit(input logic [TAGW-1:0] q);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(size); k++) begin
      if (cdb_rdy[k] && (cdb_tag[k] == q)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Scan from the top so the lowest matching lane wins.
  function automatic logic [31:0] cdb_val(input logic [TAGW-1:0] q);
    logic [31:0] val;
    val = '0;
    for (int k = int'(size) - 1; k >= 0; k--) begin
      if (cdb_rdy[k] && (cdb_tag[k] == q)) val = cdb_data[k];
    end
    return val;
  endfunction

  always_comb begin
    alu_ready = busy_q & v1_q & v2_q;
    count     = '0;
    for (int i = 0; i < int'(size); i++) begin
      alu_data[i] = {op_q[i], r1_q[i], r2_q[i], tag_q[i]};
      count       = count + CntW'(busy_q[i]);
    end
    full = (count == CntW'(size));
  end

  // Only entries idle in registered state are eligible; an issuing entry frees next cycle.
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    for (int i = int'(size) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_hit = 1'b1;
        alloc_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    tag_d  = tag_q;
    r1_d   = r1_q;
    r2_d   = r2_q;
    q1_d   = q1_q;
    q2_d   = q2_q;
    v1_d   = v1_q;
    v2_d   = v2_q;

    for (int i = 0; i < int'(size); i++) begin
      if (alu_ready[i]) busy_d[i] = 1'b0;
      if (busy_q[i] && !v1_q[i] && cdb_hit(q1_q[i])) begin
        r1_d[i] = cdb_val(q1_q[i]);
        v1_d[i] = 1'b1;
      end
      if (busy_q[i] && !v2_q[i] && cdb_hit(q2_q[i])) begin
        r2_d[i] = cdb_val(q2_q[i]);
        v2_d[i] = 1'b1;
      end
    end

    if (dis_valid && !full && !flush && alloc_hit) begin
      busy_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]   = dis_op;
      tag_d[alloc_idx]  = dis_tag;
      q1_d[alloc_idx]   = dis_q1;
      q2_d[alloc_idx]   = dis_q2;
      r1_d[alloc_idx]   = dis_r1;
      v1_d[alloc_idx]   = dis_v1;
      r2_d[alloc_idx]   = dis_r2;
      v2_d[alloc_idx]   = dis_v2;
      // Same-cycle broadcast bypass so the wakeup is not missed.
      if (!dis_v1 && cdb_hit(dis_q1)) begin
        r1_d[alloc_idx] = cdb_val(dis_q1);
        v1_d[alloc_idx] = 1'b1;
      end
      if (!dis_v2 && cdb_hit(dis_q2)) begin
        r2_d[alloc_idx] = cdb_val(dis_q2);
        v2_d[alloc_idx] = 1'b1;
      end
    end

    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      op_q   <= '0;
      tag_q  <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      q1_q   <= '0;
      q2_q   <= '0;
      v1_q   <= '0;
      v2_q   <= '0;
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      tag_q  <= tag_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      q1_q   <= q1_d;
      q2_q   <= q2_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic against an
// entry-table reference model.
module tb_alu_rs;
  localparam int Size = 8;
  localparam int TagW = 4;
  localparam int EntW = 3 + 32 + 32 + TagW;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic                       dis_valid;
  logic [2:0]                 dis_op;
  logic [TagW-1:0]            dis_tag;
  logic [31:0]                dis_r1, dis_r2;
  logic [TagW-1:0]            dis_q1, dis_q2;
  logic                       dis_v1, dis_v2;
  logic                       full;
  logic [3:0]                 count;
  logic [Size-1:0][EntW-1:0]  alu_data;
  logic [Size-1:0]            alu_ready;
  logic [Size-1:0][31:0]      cdb_data;
  logic [Size-1:0][TagW-1:0]  cdb_tag;
  logic [Size-1:0]            cdb_rdy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_rs #(.size(Size), .TAGW(TagW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dis_valid(dis_valid), .dis_op(dis_op),
    .dis_tag(dis_tag), .dis_r1(dis_r1), .dis_r2(dis_r2), .dis_q1(dis_q1), .dis_q2(dis_q2),
    .dis_v1(dis_v1), .dis_v2(dis_v2), .full(full), .count(count), .alu_data(alu_data),
    .alu_ready(alu_ready), .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_rdy(cdb_rdy)
  );

  typedef struct {
    bit        busy;
    bit [2:0]  op;
    bit [3:0]  tag;
    bit [31:0] r1, r2;
    bit [3:0]  q1, q2;
    bit        v1, v2;
  } ent_t;

  ent_t m [Size];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < Size; i++) c += int'(m[i].busy);
    return c;
  endfunction

  function automatic bit [Size-1:0] m_ready();
    bit [Size-1:0] r = '0;
    for (int i = 0; i < Size; i++) r[i] = m[i].busy & m[i].v1 & m[i].v2;
    return r;
  endfunction

  function automatic bit bus_lookup(input bit [3:0] q, output bit [31:0] d);
    d = '0;
    for (int k = 0; k < Size; k++) begin
      if (cdb_rdy[k] && cdb_tag[k] == q) begin
        d = cdb_data[k];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < Size; i++) m[i] = '{default: 0};
  endtask

  // Applies one clock edge's worth of behaviour using the inputs present at that edge.
  task automatic model_step();
    ent_t nx [Size];
    bit [31:0] d;
    int cnt;
    nx = m;
    cnt = m_count();
    for (int i = 0; i < Size; i++) begin
      if (!m[i].busy) continue;
      if (m[i].v1 && m[i].v2) nx[i].busy = 1'b0;
      if (!m[i].v1 && bus_lookup(m[i].q1, d)) begin nx[i].r1 = d; nx[i].v1 = 1'b1; end
      if (!m[i].v2 && bus_lookup(m[i].q2, d)) begin nx[i].r2 = d; nx[i].v2 = 1'b1; end
    end
    if (dis_valid && !flush && cnt < Size) begin
      for (int i = 0; i < Size; i++) begin
        if (!m[i].busy) begin
          nx[i].busy = 1'b1; nx[i].op = dis_op; nx[i].tag = dis_tag;
          nx[i].q1 = dis_q1; nx[i].q2 = dis_q2;
          nx[i].v1 = dis_v1; nx[i].r1 = dis_r1;
          nx[i].v2 = dis_v2; nx[i].r2 = dis_r2;
          if (!dis_v1 && bus_lookup(dis_q1, d)) begin nx[i].r1 = d; nx[i].v1 = 1'b1; end
          if (!dis_v2 && bus_lookup(dis_q2, d)) begin nx[i].r2 = d; nx[i].v2 = 1'b1; end
          break;
        end
      end
    end
    if (flush) for (int i = 0; i < Size; i++) nx[i].busy = 1'b0;
    m = nx;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; dis_valid = 1'b0; dis_op = '0; dis_tag = '0;
    dis_r1 = '0; dis_r2 = '0; dis_q1 = '0; dis_q2 = '0; dis_v1 = 1'b0; dis_v2 = 1'b0;
    cdb_rdy = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic dispatch(input bit [2:0] op, input bit [3:0] tag,
                          input bit [31:0] r1, input bit v1, input bit [3:0] q1,
                          input bit [31:0] r2, input bit v2, input bit [3:0] q2);
    dis_valid = 1'b1; dis_op = op; dis_tag = tag;
    dis_r1 = r1; dis_v1 = v1; dis_q1 = q1;
    dis_r2 = r2; dis_v2 = v2; dis_q2 = q2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL por_count got %0d want 0", count); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL por_full got %b want 0", full); end
    n_cmp++; if (alu_ready !== 8'h00) begin n_fail++; $display("FAIL por_ready got %h want 00", alu_ready); end
    n_cmp++; if (alu_data !== '0) begin n_fail++; $display("FAIL por_data got %h want 0", alu_data); end
    model_reset();
    #10 rst = 1'b0;
    cycle();
    // Three busy entries, then an asynchronous reset between edges.
    for (int i = 0; i < 3; i++) begin
      dispatch(3'd0, 4'(i), 32'd1, 1'b1, 4'd0, 32'd2, 1'b0, 4'd9);
      cycle();
    end
    idle();
    n_cmp++; if (count !== 4'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_full got %b want 0", full); end
    n_cmp++; if (alu_ready !== 8'h00) begin n_fail++; $display("FAIL mid_ready got %h want 00", alu_ready); end
    n_cmp++; if (alu_data !== '0) begin n_fail++; $display("FAIL mid_data got %h want 0", alu_data); end
    model_reset();
    #2 rst = 1'b0;
  endtask

  task automatic test_simple_issue();
    dispatch(3'd0, 4'd3, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0);
    cycle();
    idle();
    n_cmp++; if (alu_ready !== 8'h01) begin n_fail++; $display("FAIL simple_ready got %h want 01", alu_ready); end
    n_cmp++;
    if (alu_data[0] !== {3'd0, 32'd5, 32'd7, 4'd3}) begin
      n_fail++; $display("FAIL simple_data got %h want %h", alu_data[0], {3'd0, 32'd5, 32'd7, 4'd3});
    end
    cycle();
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL simple_free got %0d want 0", count); end
    n_cmp++; if (alu_ready !== 8'h00) begin n_fail++; $display("FAIL simple_idle got %h want 00", alu_ready); end
  endtask

  task automatic test_wakeup();
    dispatch(3'd3, 4'd4, 32'd0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0);
    cycle();
    idle();
    cycle();
    cdb_rdy[5] = 1'b1; cdb_tag[5] = 4'd2; cdb_data[5] = 32'd10;
    n_cmp++; if (alu_ready !== 8'h00) begin n_fail++; $display("FAIL wake_wait got %h want 00", alu_ready); end
    cycle();
    idle();
    n_cmp++; if (alu_ready !== 8'h01) begin n_fail++; $display("FAIL wake_ready got %h want 01", alu_ready); end
    n_cmp++;
    if (alu_data[0] !== {3'd3, 32'd10, 32'd1, 4'd4}) begin
      n_fail++; $display("FAIL wake_data got %h want %h", alu_data[0], {3'd3, 32'd10, 32'd1, 4'd4});
    end
    cycle();
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL wake_free got %0d want 0", count); end
  endtask

  task automatic test_bypass();
    dispatch(3'd4, 4'd5, 32'd3, 1'b1, 4'd0, 32'd0, 1'b0, 4'd6);
    cdb_rdy[0] = 1'b1; cdb_tag[0] = 4'd6; cdb_data[0] = 32'hFFFF_FFFF;
    cycle();
    idle();
    n_cmp++; if (alu_ready !== 8'h01) begin n_fail++; $display("FAIL bypass_ready got %h want 01", alu_ready); end
    n_cmp++;
    if (alu_data[0] !== {3'd4, 32'd3, 32'hFFFF_FFFF, 4'd5}) begin
      n_fail++; $display("FAIL bypass_data got %h want %h", alu_data[0], {3'd4, 32'd3, 32'hFFFF_FFFF, 4'd5});
    end
    cycle();
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL bypass_free got %0d want 0", count); end
  endtask

  task automatic test_full_drop();
    for (int i = 0; i < Size; i++) begin
      dispatch(3'd6, 4'(i), 32'd0, 1'b0, 4'(i + 8), 32'd2, 1'b1, 4'd0);
      cycle();
    end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", full); end
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", count); end
    dispatch(3'd1, 4'd15, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
    cycle();
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL drop_count got %0d want 8", count); end
    n_cmp++; if (alu_ready !== 8'h00) begin n_fail++; $display("FAIL drop_ready got %h want 00", alu_ready); end
    n_cmp++;
    if (alu_data[7][3:0] !== 4'd7) begin n_fail++; $display("FAIL drop_tag got %0d want 7", alu_data[7][3:0]); end
    idle();
    cdb_rdy[3] = 1'b1; cdb_tag[3] = 4'd10; cdb_data[3] = 32'd42;
    cycle();
    idle();
    n_cmp++; if (alu_ready !== 8'h04) begin n_fail++; $display("FAIL full_wake got %h want 04", alu_ready); end
    n_cmp++;
    if (alu_data[2][67:36] !== 32'd42) begin n_fail++; $display("FAIL full_wake_r1 got %0d want 42", alu_data[2][67:36]); end
    // Entry 2 is issuing but not yet free: this dispatch must be dropped.
    dispatch(3'd7, 4'd14, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
    cycle();
    n_cmp++; if (count !== 4'd7) begin n_fail++; $display("FAIL issue_free got %0d want 7", count); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL issue_full got %b want 0", full); end
    dispatch(3'd7, 4'd13, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
    cycle();
    idle();
    n_cmp++; if (alu_ready !== 8'h04) begin n_fail++; $display("FAIL realloc_ready got %h want 04", alu_ready); end
    n_cmp++;
    if (alu_data[2][3:0] !== 4'd13) begin n_fail++; $display("FAIL realloc_tag got %0d want 13", alu_data[2][3:0]); end
    flush = 1'b1;
    cycle();
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      dispatch(3'd2, 4'(i), 32'd0, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0);
      cycle();
    end
    n_cmp++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre got %0d want 5", count); end
    dispatch(3'd0, 4'd1, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
    flush = 1'b1;
    cdb_rdy[1] = 1'b1; cdb_tag[1] = 4'd9; cdb_data[1] = 32'd77;
    cycle();
    idle();
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (alu_ready !== 8'h00) begin n_fail++; $display("FAIL flush_ready got %h want 00", alu_ready); end
    cycle();
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_after got %0d want 0", count); end
  endtask

  task automatic test_random();
    bit [Size-1:0] er;
    for (int c = 0; c < 500; c++) begin
      dispatch(3'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom_range(0, 3)),
               $urandom, 1'($urandom), 4'($urandom_range(0, 3)));
      dis_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < Size; k++) begin
        cdb_rdy[k] = ($urandom_range(0, 5) == 0);
        cdb_tag[k] = 4'($urandom_range(0, 3));
        cdb_data[k] = $urandom;
      end
      cycle();
      er = m_ready();
      n_cmp++;
      if (count !== 4'(m_count())) begin
        n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, count, m_count());
      end
      n_cmp++;
      if (full !== (m_count() == Size)) begin
        n_fail++; $display("FAIL rnd_full cyc %0d got %b want %b", c, full, m_count() == Size);
      end
      n_cmp++;
      if (alu_ready !== er) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d got %h want %h", c, alu_ready, er);
      end
      for (int i = 0; i < Size; i++) begin
        if (er[i]) begin
          n_cmp++;
          if (alu_data[i] !== {m[i].op, m[i].r1, m[i].r2, m[i].tag}) begin
            n_fail++; $display("FAIL rnd_data cyc %0d ent %0d got %h want %h", c, i, alu_data[i],
                               {m[i].op, m[i].r1, m[i].r2, m[i].tag});
          end
        end else if (m[i].busy) begin
          n_cmp++;
          if ({alu_data[i][70:68], alu_data[i][3:0]} !== {m[i].op, m[i].tag}) begin
            n_fail++; $display("FAIL rnd_optag cyc %0d ent %0d got %h want %h", c, i,
                               {alu_data[i][70:68], alu_data[i][3:0]}, {m[i].op, m[i].tag});
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_simple_issue();
    test_wakeup();
    test_bypass();
    test_full_drop();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
Reservation station feeding the combinational ALU array. Entry i drives ALU lane i. It accepts one decoded ALU op per cycle from dispatch, holds it until both operands are resolved, then presents the entry with its ready bit to the ALU. It snoops the ALU result bus (data/tag/rdy per lane) to wake waiting operands and frees each entry the cycle after it issues.

Parameters:
size, 8, number of entries; equals the number of ALU lanes
TAGW, 4, ROB tag width; matches the ALU output tag field

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous squash of all entries (mispredict)
dis_valid  in  1  dispatch request
dis_op  in  3  alu_ops encoding (add, sll, sra, sub, xor, srl, or, and)
dis_tag  in  TAGW  destination ROB tag
dis_r1, dis_r2  in  32 each  operand value; meaningful when the matching _v bit is 1
dis_q1, dis_q2  in  TAGW each  producer tag; meaningful when the matching _v bit is 0
dis_v1, dis_v2  in  1 each  operand already valid
full  out  1  all entries occupied
count  out  $clog2(size+1)  number of occupied entries
alu_data  out  rs_t[size]  per-entry operation, r1, r2, tag to the ALU
alu_ready  out  [size]  per-entry issue strobe to the ALU
cdb_data  in  32[size]  ALU lane result
cdb_tag  in  TAGW[size]  ALU lane tag
cdb_rdy  in  [size]  ALU lane valid

Behaviour:
- Per-entry state: busy, op, tag, r1, q1, v1, r2, q2, v2. alu_data[i] is driven directly from entry i's registers.
- Reset (async, rst=1): clear every busy, v1, v2 and all data fields to 0. While rst is asserted: full=0, count=0, alu_ready=0, alu_data all 0.
- Ready signal: alu_ready[i] = busy[i] & v1[i] & v2[i]. It is combinational from registered state only; it never depends on cdb or dispatch in the same cycle.
- Issue and free: if alu_ready[i]=1 at a rising edge, entry i has issued and busy[i] clears at that edge. The ALU is combinational, so the result appears on cdb in that same cycle.
- Allocation:
  - When dis_valid=1, full=0 and flush=0, write the lowest-index entry with busy=0 at the edge.
  - An entry issuing in the current cycle is not free until the next cycle; it is never reallocated in the same cycle.
- Dispatch while full: dis_valid=1 with full=1 is dropped. The state is unchanged and no error is raised; the upstream stage must stall on full.
- Wakeup: at each edge, for every busy entry with v1=0, if some k has cdb_rdy[k]=1 and cdb_tag[k]=q1, load r1=cdb_data[k] and set v1=1. The same rule applies to operand 2. If several lanes match, the lowest k wins.
- Dispatch bypass: a dispatching operand with v=0 whose q matches a cdb broadcast in the same cycle is written with the cdb data and v=1, so the wakeup is not missed.
- Wakeup timing: an entry woken at edge N asserts alu_ready in cycle N+1. Minimum dispatch-to-issue latency is 1 cycle (both operands valid at dispatch).
- Flush: flush=1 clears all busy bits at the edge. It has priority over dispatch and wakeup, and the concurrent dispatch is discarded. alu_ready is not gated combinationally during the flush cycle.
- full = (count == size). count is popcount(busy), registered state only.
- Tag 0 is a legal ROB tag. Wakeup is qualified only by cdb_rdy, never by the tag value.

Test Plan:
- Reset mid-operation: 3 busy entries, assert rst asynchronously between edges -> alu_ready=0, count=0, full=0 immediately, without waiting for a clock edge.
- Simple issue: dispatch add, r1=5, r2=7, both valid, tag=3 -> next cycle alu_ready[0]=1, alu_data[0]={add,5,7,3}; the following cycle busy[0]=0 and count=0.
- Wakeup: dispatch sub, tag=4, v1=0, q1=2, r2=1 valid; 2 cycles later drive cdb_rdy[5]=1, tag=2, data=10 -> alu_ready[0]=1 the next cycle with r1=10.
- Dispatch bypass: dispatch with q2=6 in the same cycle cdb broadcasts tag 6, data 0xFFFF_FFFF -> entry stored with v2=1 and r2=0xFFFF_FFFF; issues the next cycle.
- Full and drop: dispatch 8 ops with unresolved operands -> full=1, count=8; a 9th dispatch is ignored. Wake entry 2 -> it issues; after it frees, a new dispatch lands in entry 2.
- Flush priority: 5 entries busy, assert flush together with a dis_valid -> next cycle count=0, no entry allocated, alu_ready all 0.
